// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU-control sequencer: ALUOp modes,
// funct/opcode encodings, ALU select codes and the sequencer state.
package alu_ctrl_pkg;

    localparam logic [2:0] OPA_ADD   = 3'b000;
    localparam logic [2:0] OPA_SUB   = 3'b001;
    localparam logic [2:0] OPA_FUNCT = 3'b010;
    localparam logic [2:0] OPA_OPC   = 3'b011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_MULT = 4'b0010;
    localparam logic [3:0] SEL_DIV  = 4'b0011;
    localparam logic [3:0] SEL_OR   = 4'b0100;
    localparam logic [3:0] SEL_AND  = 4'b0101;
    localparam logic [3:0] SEL_SLT  = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_ADDI = 4'b1000;
    localparam logic [3:0] SEL_SLTI = 4'b1001;
    localparam logic [3:0] SEL_ANDI = 4'b1010;
    localparam logic [3:0] SEL_ORI  = 4'b1011;
    localparam logic [3:0] SEL_SW   = 4'b1100;
    localparam logic [3:0] SEL_LW   = 4'b1101;
    localparam logic [3:0] SEL_BEQ  = 4'b1110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       illegal;
        logic       is_md;
        logic       md_op;   // 0 = MULT, 1 = DIV
    } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct/opcode decode into ALU select plus MD classification.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter logic [3:0] ILL_SEL = 4'b1111
) (
    input  logic [2:0] opa_i,
    input  logic [5:0] itr_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '{sel: ILL_SEL, illegal: 1'b1, is_md: 1'b0, md_op: 1'b0};
        case (opa_i)
            OPA_ADD: dec_o = '{sel: SEL_ADD, illegal: 1'b0, is_md: 1'b0, md_op: 1'b0};
            OPA_SUB: dec_o = '{sel: SEL_SUB, illegal: 1'b0, is_md: 1'b0, md_op: 1'b0};
            OPA_FUNCT: begin
                dec_o.illegal = 1'b0;
                case (itr_i)
                    F_ADD:  dec_o.sel = SEL_ADD;
                    F_SUB:  dec_o.sel = SEL_SUB;
                    F_MULT: begin dec_o.sel = SEL_MULT; dec_o.is_md = 1'b1; end
                    F_DIV:  begin dec_o.sel = SEL_DIV;  dec_o.is_md = 1'b1; dec_o.md_op = 1'b1; end
                    F_OR:   dec_o.sel = SEL_OR;
                    F_AND:  dec_o.sel = SEL_AND;
                    F_SLT:  dec_o.sel = SEL_SLT;
                    F_SLL:  dec_o.sel = SEL_SLL;
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OPA_OPC: begin
                dec_o.illegal = 1'b0;
                case (itr_i)
                    OP_ADDI: dec_o.sel = SEL_ADDI;
                    OP_SLTI: dec_o.sel = SEL_SLTI;
                    OP_ANDI: dec_o.sel = SEL_ANDI;
                    OP_ORI:  dec_o.sel = SEL_ORI;
                    OP_SW:   dec_o.sel = SEL_SW;
                    OP_LW:   dec_o.sel = SEL_LW;
                    OP_BEQ:  dec_o.sel = SEL_BEQ;
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU-control sequencer: registers the decoded select behind
// valid/ready and stalls issue while a MULT/DIV runs in the MD unit.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int         MUL_LAT = 4,
    parameter int         DIV_LAT = 32,
    parameter logic [3:0] ILL_SEL = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [2:0] opa_i,
    input  logic [5:0] itr_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [3:0] sel_o,
    output logic       illegal_o,
    output logic       md_start_o,
    output logic       md_op_o,
    output logic       busy_o
);

    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    dec_t          dec;
    logic          accept;

    alu_ctrl_dec #(.ILL_SEL(ILL_SEL)) u_dec (
        .opa_i (opa_i),
        .itr_i (itr_i),
        .dec_o (dec)
    );

    assign accept = valid_i && ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = dec.is_md ? S_RUN : S_OUT;
            S_RUN:  if (cnt == '0) state_nx = S_OUT;
            S_OUT: begin
                // Handshake and a fresh accept may share the same edge.
                if (accept)       state_nx = dec.is_md ? S_RUN : S_OUT;
                else if (ready_i) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == S_IDLE) || (state == S_OUT && ready_i);
        valid_o = (state == S_OUT);
        busy_o  = (state == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_o      <= '0;
            illegal_o  <= 1'b0;
            md_op_o    <= 1'b0;
            md_start_o <= 1'b0;
            cnt        <= '0;
        end else begin
            md_start_o <= accept && dec.is_md;
            if (accept) begin
                sel_o     <= dec.sel;
                illegal_o <= dec.illegal;
                md_op_o   <= dec.md_op;
            end
            // Loading LAT-1 gives exactly LAT cycles in RUN, including LAT=1.
            if (accept && dec.is_md)
                cnt <= dec.md_op ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            else if (state == S_RUN && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized self-checking bench for alu_ctrl_seq against a table-driven model.
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [2:0] opa_i = '0;
    logic [5:0] itr_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic [3:0] sel_o;
    logic       illegal_o;
    logic       md_start_o;
    logic       md_op_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ILL_SEL(4'b1111)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .opa_i(opa_i), .itr_i(itr_i), .valid_o(valid_o), .ready_i(ready_i),
        .sel_o(sel_o), .illegal_o(illegal_o), .md_start_o(md_start_o),
        .md_op_o(md_op_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference tables: {code, select}
    logic [5:0] fn_code [8] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                                6'b100101, 6'b100100, 6'b101010, 6'b000000};
    logic [3:0] fn_sel  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [5:0] oc_code [7] = '{6'b001000, 6'b001010, 6'b001100, 6'b001101,
                                6'b101011, 6'b100011, 6'b000100};
    logic [3:0] oc_sel  [7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

    function automatic void ref_dec(input logic [2:0] opa, input logic [5:0] itr,
                                    output logic [3:0] sel, output logic ill,
                                    output logic md, output logic op);
        sel = 4'b1111; ill = 1'b1; md = 1'b0; op = 1'b0;
        if (opa == 3'd0) begin sel = 4'd0; ill = 1'b0; end
        else if (opa == 3'd1) begin sel = 4'd1; ill = 1'b0; end
        else if (opa == 3'd2) begin
            for (int k = 0; k < 8; k++)
                if (fn_code[k] == itr) begin sel = fn_sel[k]; ill = 1'b0; end
            md = !ill && (sel == 4'd2 || sel == 4'd3);
            op = md && (sel == 4'd3);
        end else if (opa == 3'd3) begin
            for (int k = 0; k < 7; k++)
                if (oc_code[k] == itr) begin sel = oc_sel[k]; ill = 1'b0; end
        end
    endfunction

    // One full request: issue, wait through RUN if MD, optional backpressure, handshake.
    task automatic issue(input logic [2:0] opa, input logic [5:0] itr, input int hold);
        logic [3:0] es; logic ei, em, eo; int n, lat;
        ref_dec(opa, itr, es, ei, em, eo);
        lat = eo ? DIV_LAT : MUL_LAT;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready got=%b exp=1", ready_o); end
        valid_i = 1'b1; opa_i = opa; itr_i = itr; ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        if (em) begin
            checks++; if (md_start_o !== 1'b1 || md_op_o !== eo) begin errors++;
                $display("FAIL md_start got=%b/%b exp=1/%b", md_start_o, md_op_o, eo); end
            n = 0;
            while (busy_o === 1'b1 && n < 100) begin
                if (n > 0) begin
                    checks++; if (md_start_o !== 1'b0) begin errors++; $display("FAIL md_start_width got=%b exp=0 cyc=%0d", md_start_o, n); end
                end
                checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin errors++;
                    $display("FAIL run_ready got=%b/%b exp=0/0", ready_o, valid_o); end
                n++;
                valid_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                valid_i = 1'b0;
            end
            checks++; if (n != lat) begin errors++; $display("FAIL busy_cycles got=%0d exp=%0d", n, lat); end
        end
        checks++; if (valid_o !== 1'b1 || sel_o !== es || illegal_o !== ei || md_start_o !== 1'b0) begin errors++;
            $display("FAIL result opa=%b itr=%b got v=%b sel=%b ill=%b st=%b exp v=1 sel=%b ill=%b st=0",
                     opa, itr, valid_o, sel_o, illegal_o, md_start_o, es, ei); end
        if (hold > 0) begin
            ready_i = 1'b0;
            for (int k = 0; k < hold; k++) begin
                #1;
                checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", ready_o); end
                @(negedge clk);
                checks++; if (valid_o !== 1'b1 || sel_o !== es || illegal_o !== ei) begin errors++;
                    $display("FAIL bp_hold got v=%b sel=%b exp v=1 sel=%b", valid_o, sel_o, es); end
            end
            ready_i = 1'b1;
        end
        @(negedge clk);
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++;
            $display("FAIL handshake got v=%b rdy=%b exp v=0 rdy=1", valid_o, ready_o); end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (valid_o !== 1'b0 || sel_o !== 4'b0000 || illegal_o !== 1'b0 || md_start_o !== 1'b0 ||
            md_op_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s got v=%b sel=%b ill=%b st=%b op=%b busy=%b rdy=%b exp 0 0000 0 0 0 0 1",
                     tag, valid_o, sel_o, illegal_o, md_start_o, md_op_o, busy_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid_i = 1'b1; opa_i = 3'b010; itr_i = 6'b100000; ready_i = 1'b1;
        @(negedge clk);
        checks++; if (valid_o !== 1'b1 || sel_o !== 4'b0000) begin errors++;
            $display("FAIL b2b_first got v=%b sel=%b exp v=1 sel=0000", valid_o, sel_o); end
        itr_i = 6'b100100;
        @(negedge clk);
        checks++; if (valid_o !== 1'b1 || sel_o !== 4'b0101) begin errors++;
            $display("FAIL b2b_second got v=%b sel=%b exp v=1 sel=0101", valid_o, sel_o); end
        valid_i = 1'b0;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", valid_o); end
    endtask

    task automatic test_modes();
        issue(3'b011, 6'b101011, 0);
        issue(3'b000, 6'($urandom), 0);
        issue(3'b001, 6'($urandom), 0);
        issue(3'b111, 6'b000000, 0);
        issue(3'b010, 6'b111111, 0);
    endtask

    task automatic test_mult();
        issue(3'b010, 6'b011000, 0);
    endtask

    task automatic test_backpressure();
        issue(3'b010, 6'b101010, 3);
    endtask

    task automatic test_reset_mid_out();
        @(negedge clk);
        valid_i = 1'b1; opa_i = 3'b011; itr_i = 6'b100011;
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("reset_mid_out");
        @(negedge clk);
        rst = 1'b0; ready_i = 1'b1;
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge clk);
        valid_i = 1'b1; opa_i = 3'b010; itr_i = 6'b011010;
        @(negedge clk);
        valid_i = 1'b0;
        // First RUN cycle holds count 31; 21 cycles later it holds 10.
        repeat (21) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", busy_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || md_start_o !== 1'b0 || valid_o !== 1'b0) begin errors++;
            $display("FAIL abort_async got busy=%b st=%b v=%b exp 0 0 0", busy_o, md_start_o, valid_o); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || md_start_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ghost got=1 exp=0"); end
        issue(3'b000, 6'($urandom), 0);
    endtask

    task automatic test_random();
        logic [2:0] opa; logic [5:0] itr; int pick;
        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 4) begin
                opa = 3'b010; itr = fn_code[$urandom_range(0, 7)];
            end else if (pick < 7) begin
                opa = 3'b011; itr = oc_code[$urandom_range(0, 6)];
            end else begin
                opa = 3'($urandom); itr = 6'($urandom);
            end
            issue(opa, itr, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_modes();
        test_mult();
        test_backpressure();
        test_reset_mid_out();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
